// File: rtl/decode_ctrl_mc.sv
// ID/EX decode controller: decodes RV32I+M into a registered EX control bundle and
// tracks occupancy of the iterative mul/div unit, holding the front end while it is busy.
module decode_ctrl_mc #(
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 33,
   parameter bit ENABLE_M   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid_i,
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   input  logic       stall_i,
   input  logic       flush_i,
   output logic       stall_o,
   output logic       ex_valid_o,
   output logic [1:0] ex_result_src_o,
   output logic       ex_mem_write_o,
   output logic       ex_mem_read_o,
   output logic       ex_alu_src_o,
   output logic       ex_reg_write_o,
   output logic       ex_jump_o,
   output logic       ex_branch_o,
   output logic [2:0] ex_imm_src_o,
   output logic [4:0] ex_alu_ctrl_o,
   output logic       ex_md_last_o,
   output logic       ex_illegal_o
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [4:0] ALU_ADD  = 5'h00;
   localparam logic [4:0] ALU_SUB  = 5'h01;
   localparam logic [4:0] ALU_AND  = 5'h02;
   localparam logic [4:0] ALU_OR   = 5'h03;
   localparam logic [4:0] ALU_XOR  = 5'h04;
   localparam logic [4:0] ALU_SLT  = 5'h05;
   localparam logic [4:0] ALU_SLTU = 5'h06;
   localparam logic [4:0] ALU_SLL  = 5'h07;
   localparam logic [4:0] ALU_SRL  = 5'h08;
   localparam logic [4:0] ALU_SRA  = 5'h09;

   localparam logic [7:0] MUL_LAT = 8'(MUL_CYCLES);
   localparam logic [7:0] DIV_LAT = 8'(DIV_CYCLES);

   typedef struct packed {
      logic [1:0] result_src;
      logic       mem_write;
      logic       mem_read;
      logic       alu_src;
      logic       reg_write;
      logic       jump;
      logic       branch;
      logic [2:0] imm_src;
      logic [4:0] alu_ctrl;
      logic       illegal;
   } ctl_t;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   logic [7:0] cnt;
   ctl_t       dec_p0;
   ctl_t       ex_p1;
   logic       vld_p1;
   logic [7:0] lat_p0;

   function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
      logic [4:0] r;
      case (f3)
         3'b000:  r = alt ? ALU_SUB : ALU_ADD;
         3'b001:  r = ALU_SLL;
         3'b010:  r = ALU_SLT;
         3'b011:  r = ALU_SLTU;
         3'b100:  r = ALU_XOR;
         3'b101:  r = alt ? ALU_SRA : ALU_SRL;
         3'b110:  r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

   // ID: combinational decode of the instruction presented by the front end
   always_comb begin
      dec_p0 = '0;
      case (op_i)
         OP_LOAD: begin
            dec_p0.result_src = 2'b01;
            dec_p0.mem_read   = 1'b1;
            dec_p0.alu_src    = 1'b1;
            dec_p0.reg_write  = 1'b1;
         end
         OP_STORE: begin
            dec_p0.mem_write = 1'b1;
            dec_p0.alu_src   = 1'b1;
            dec_p0.imm_src   = 3'b001;
         end
         OP_R: begin
            if (funct7_i == 7'b0000001) begin
               if (ENABLE_M) begin
                  dec_p0.reg_write = 1'b1;
                  dec_p0.alu_ctrl  = {2'b10, funct3_i};
               end else begin
                  dec_p0.illegal = 1'b1;
               end
            end else begin
               dec_p0.reg_write = 1'b1;
               dec_p0.alu_ctrl  = alu_base(funct3_i, funct7_i[5]);
            end
         end
         OP_I: begin
            // addi never becomes sub; only srai honours funct7[5]
            dec_p0.reg_write = 1'b1;
            dec_p0.alu_src   = 1'b1;
            dec_p0.alu_ctrl  = alu_base(funct3_i, (funct3_i == 3'b101) & funct7_i[5]);
         end
         OP_BR: begin
            dec_p0.branch   = 1'b1;
            dec_p0.imm_src  = 3'b010;
            dec_p0.alu_ctrl = funct3_i[2] ? (funct3_i[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
         end
         OP_JAL: begin
            dec_p0.result_src = 2'b10;
            dec_p0.reg_write  = 1'b1;
            dec_p0.jump       = 1'b1;
            dec_p0.imm_src    = 3'b011;
         end
         OP_JALR: begin
            dec_p0.result_src = 2'b10;
            dec_p0.reg_write  = 1'b1;
            dec_p0.jump       = 1'b1;
            dec_p0.alu_src    = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec_p0.reg_write = 1'b1;
            dec_p0.alu_src   = 1'b1;
            dec_p0.imm_src   = 3'b100;
         end
         default: dec_p0.illegal = 1'b1;
      endcase
   end

   assign lat_p0 = funct3_i[2] ? DIV_LAT : MUL_LAT;

   // EX: registered bundle plus mul/div occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         ex_p1  <= '0;
         vld_p1 <= 1'b0;
      end else if (flush_i) begin
         state  <= IDLE;
         cnt    <= 8'd0;
         ex_p1  <= '0;
         vld_p1 <= 1'b0;
      end else if (!stall_i) begin
         if (state == BUSY) begin
            if (cnt == 8'd1) begin
               state <= IDLE;
               cnt   <= 8'd0;
            end else begin
               cnt <= cnt - 8'd1;
            end
         end else if (id_valid_i) begin
            ex_p1  <= dec_p0;
            vld_p1 <= 1'b1;
            if (dec_p0.alu_ctrl[4] && (lat_p0 > 8'd1)) begin
               state <= BUSY;
               cnt   <= lat_p0 - 8'd1;
            end
         end else begin
            ex_p1  <= '0;
            vld_p1 <= 1'b0;
         end
      end
   end

   assign stall_o         = (state == BUSY);
   assign ex_valid_o      = vld_p1;
   assign ex_result_src_o = ex_p1.result_src;
   assign ex_mem_write_o  = ex_p1.mem_write;
   assign ex_mem_read_o   = ex_p1.mem_read;
   assign ex_alu_src_o    = ex_p1.alu_src;
   assign ex_reg_write_o  = ex_p1.reg_write;
   assign ex_jump_o       = ex_p1.jump;
   assign ex_branch_o     = ex_p1.branch;
   assign ex_imm_src_o    = ex_p1.imm_src;
   assign ex_alu_ctrl_o   = ex_p1.alu_ctrl;
   assign ex_illegal_o    = ex_p1.illegal;
   assign ex_md_last_o    = vld_p1 & ex_p1.alu_ctrl[4] & (state == IDLE);

endmodule

// File: tb/tb_decode_ctrl_mc.sv
// Bench for decode_ctrl_mc: decode vector table, hand-written mul/div sequences and
// random traffic checked against an occupancy-count reference model.
module tb_decode_ctrl_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       id_valid = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
   logic [6:0] op = '0, f7 = '0;
   logic [2:0] f3 = '0;

   logic       a_stall, a_valid, a_mw, a_mr, a_as, a_rw, a_j, a_b, a_md_last, a_ill;
   logic [1:0] a_rs;
   logic [2:0] a_imm;
   logic [4:0] a_alu;

   logic       b_id_valid = 1'b0, b_stall_i = 1'b0, b_flush_i = 1'b0;
   logic [6:0] b_op = '0, b_f7 = '0;
   logic [2:0] b_f3 = '0;
   logic       b_stall, b_valid, b_mw, b_mr, b_as, b_rw, b_j, b_b, b_md_last, b_ill;
   logic [1:0] b_rs;
   logic [2:0] b_imm;
   logic [4:0] b_alu;

   decode_ctrl_mc #(.MUL_CYCLES(3), .DIV_CYCLES(33), .ENABLE_M(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .op_i(op), .funct3_i(f3), .funct7_i(f7),
      .stall_i(stall_i), .flush_i(flush_i), .stall_o(a_stall), .ex_valid_o(a_valid),
      .ex_result_src_o(a_rs), .ex_mem_write_o(a_mw), .ex_mem_read_o(a_mr), .ex_alu_src_o(a_as),
      .ex_reg_write_o(a_rw), .ex_jump_o(a_j), .ex_branch_o(a_b), .ex_imm_src_o(a_imm),
      .ex_alu_ctrl_o(a_alu), .ex_md_last_o(a_md_last), .ex_illegal_o(a_ill));

   decode_ctrl_mc #(.MUL_CYCLES(3), .DIV_CYCLES(33), .ENABLE_M(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .id_valid_i(b_id_valid), .op_i(b_op), .funct3_i(b_f3), .funct7_i(b_f7),
      .stall_i(b_stall_i), .flush_i(b_flush_i), .stall_o(b_stall), .ex_valid_o(b_valid),
      .ex_result_src_o(b_rs), .ex_mem_write_o(b_mw), .ex_mem_read_o(b_mr), .ex_alu_src_o(b_as),
      .ex_reg_write_o(b_rw), .ex_jump_o(b_j), .ex_branch_o(b_b), .ex_imm_src_o(b_imm),
      .ex_alu_ctrl_o(b_alu), .ex_md_last_o(b_md_last), .ex_illegal_o(b_ill));

   typedef struct packed {
      logic       v;
      logic [1:0] rs;
      logic       mw, mr, as, rw, j, b;
      logic [2:0] imm;
      logic [4:0] alu;
      logic       ill;
   } ctl_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      ctl_t       exp;
   } vec_t;

   ctl_t act_a, act_b;
   assign act_a = {a_valid, a_rs, a_mw, a_mr, a_as, a_rw, a_j, a_b, a_imm, a_alu, a_ill};
   assign act_b = {b_valid, b_rs, b_mw, b_mr, b_as, b_rw, b_j, b_b, b_imm, b_alu, b_ill};

   int total = 0;
   int bad   = 0;

   // Reference state: bundle in EX and how many more cycles it stays there
   ctl_t mex = '0;
   int   occ = 0;

   function automatic ctl_t c(input logic v, input logic [1:0] rs, input logic mw, input logic mr,
                              input logic as, input logic rw, input logic j, input logic b,
                              input logic [2:0] imm, input logic [4:0] alu, input logic ill);
      return {v, rs, mw, mr, as, rw, j, b, imm, alu, ill};
   endfunction

   function automatic logic [4:0] base_code(input logic [2:0] fn3, input logic alt);
      logic [4:0] lut [8];
      lut = '{5'h00, 5'h07, 5'h05, 5'h06, 5'h04, 5'h08, 5'h03, 5'h02};
      if (alt && fn3 == 3'd0) return 5'h01;
      if (alt && fn3 == 3'd5) return 5'h09;
      return lut[fn3];
   endfunction

   function automatic ctl_t ref_decode(input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7);
      ctl_t d;
      d = '0;
      d.v = 1'b1;
      case (o)
         7'b0000011: begin d.rs = 2'd1; d.mr = 1; d.as = 1; d.rw = 1; end
         7'b0100011: begin d.mw = 1; d.as = 1; d.imm = 3'd1; end
         7'b0110011: begin
            d.rw = 1;
            d.alu = (fn7 == 7'd1) ? 5'h10 + 5'(fn3) : base_code(fn3, fn7[5]);
         end
         7'b0010011: begin
            d.rw = 1; d.as = 1;
            d.alu = (fn3 == 3'd0) ? 5'h00 : base_code(fn3, fn7[5]);
         end
         7'b1100011: begin
            d.b = 1; d.imm = 3'd2;
            d.alu = (fn3 >= 3'd6) ? 5'h06 : (fn3 >= 3'd4) ? 5'h05 : 5'h01;
         end
         7'b1101111: begin d.rs = 2'd2; d.rw = 1; d.j = 1; d.imm = 3'd3; end
         7'b1100111: begin d.rs = 2'd2; d.rw = 1; d.j = 1; d.as = 1; end
         7'b0110111, 7'b0010111: begin d.rw = 1; d.as = 1; d.imm = 3'd4; end
         default: d.ill = 1;
      endcase
      return d;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic v, input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7,
                        input logic st, input logic fl);
      ctl_t d;
      @(negedge clk);
      id_valid = v; op = o; f3 = fn3; f7 = fn7; stall_i = st; flush_i = fl;
      if (fl) begin
         mex = '0; occ = 0;
      end else if (st) begin
      end else if (occ > 1) begin
         occ--;
      end else if (v) begin
         d = ref_decode(o, fn3, fn7);
         mex = d;
         occ = d.alu[4] ? (fn3[2] ? 33 : 3) : 1;
      end else begin
         mex = '0; occ = 0;
      end
      @(posedge clk);
      #1;
      check("cycle", {12'd0, act_a, a_stall, a_md_last},
            {12'd0, mex, (occ > 1), (mex.v & mex.alu[4] & (occ <= 1))});
   endtask

   localparam logic [6:0] R = 7'b0110011;
   vec_t tbl [20];
   logic [6:0] ops [10];
   int mulc, stc, lastk, addk, mdc, occ_cnt;
   logic [6:0] rf7;
   logic [6:0] ro;

   initial begin
      tbl[0]  = '{R,          3'd0, 7'h00, c(1,0,0,0,0,1,0,0,0,5'h00,0)};
      tbl[1]  = '{R,          3'd0, 7'h20, c(1,0,0,0,0,1,0,0,0,5'h01,0)};
      tbl[2]  = '{7'b0000011, 3'd2, 7'h00, c(1,1,0,1,1,1,0,0,0,5'h00,0)};
      tbl[3]  = '{7'b0100011, 3'd2, 7'h00, c(1,0,1,0,1,0,0,0,1,5'h00,0)};
      tbl[4]  = '{7'b0010011, 3'd0, 7'h20, c(1,0,0,0,1,1,0,0,0,5'h00,0)};
      tbl[5]  = '{7'b0010011, 3'd5, 7'h20, c(1,0,0,0,1,1,0,0,0,5'h09,0)};
      tbl[6]  = '{7'b0010011, 3'd1, 7'h00, c(1,0,0,0,1,1,0,0,0,5'h07,0)};
      tbl[7]  = '{R,          3'd4, 7'h00, c(1,0,0,0,0,1,0,0,0,5'h04,0)};
      tbl[8]  = '{7'b1100011, 3'd0, 7'h00, c(1,0,0,0,0,0,0,1,2,5'h01,0)};
      tbl[9]  = '{7'b1100011, 3'd5, 7'h00, c(1,0,0,0,0,0,0,1,2,5'h05,0)};
      tbl[10] = '{7'b1100011, 3'd6, 7'h00, c(1,0,0,0,0,0,0,1,2,5'h06,0)};
      tbl[11] = '{7'b1101111, 3'd0, 7'h00, c(1,2,0,0,0,1,1,0,3,5'h00,0)};
      tbl[12] = '{7'b1100111, 3'd0, 7'h00, c(1,2,0,0,1,1,1,0,0,5'h00,0)};
      tbl[13] = '{7'b0110111, 3'd0, 7'h00, c(1,0,0,0,1,1,0,0,4,5'h00,0)};
      tbl[14] = '{7'b0010111, 3'd0, 7'h00, c(1,0,0,0,1,1,0,0,4,5'h00,0)};
      tbl[15] = '{7'b1111111, 3'd0, 7'h00, c(1,0,0,0,0,0,0,0,0,5'h00,1)};
      tbl[16] = '{R,          3'd3, 7'h00, c(1,0,0,0,0,1,0,0,0,5'h06,0)};
      tbl[17] = '{R,          3'd6, 7'h00, c(1,0,0,0,0,1,0,0,0,5'h03,0)};
      tbl[18] = '{R,          3'd7, 7'h00, c(1,0,0,0,0,1,0,0,0,5'h02,0)};
      tbl[19] = '{R,          3'd5, 7'h20, c(1,0,0,0,0,1,0,0,0,5'h09,0)};
      ops = '{7'b0000011, 7'b0100011, R, R, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", {13'd0, act_a, a_stall}, 32'd0);
      check("reset_b", {13'd0, act_b, b_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ENABLE_M=0 instance: M encoding is illegal and never stalls
      @(negedge clk);
      b_id_valid = 1'b1; b_op = R; b_f3 = 3'd4; b_f7 = 7'h01;
      @(posedge clk); #1;
      check("nom_illegal", {14'd0, act_b}, {14'd0, c(1,0,0,0,0,0,0,0,0,5'h00,1)});
      check("nom_stall", {31'd0, b_stall}, 32'd0);
      @(negedge clk);
      b_op = R; b_f3 = 3'd0; b_f7 = 7'h00;
      @(posedge clk); #1;
      check("nom_add", {14'd0, act_b}, {14'd0, c(1,0,0,0,0,1,0,0,0,5'h00,0)});
      check("nom_stall2", {31'd0, b_stall}, 32'd0);
      @(negedge clk);
      b_id_valid = 1'b0;

      repeat (3) cycle(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);

      foreach (tbl[i]) begin
         cycle(1'b1, tbl[i].op, tbl[i].f3, tbl[i].f7, 1'b0, 1'b0);
         check("table", {14'd0, act_a}, {14'd0, tbl[i].exp});
      end
      cycle(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);

      // mul (3 cycles) with add waiting behind it
      mulc = 0; stc = 0; lastk = 0; addk = 0; mdc = 0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 1) cycle(1'b1, R, 3'd0, 7'h01, 1'b0, 1'b0);
         else        cycle(1'b1, R, 3'd0, 7'h00, 1'b0, 1'b0);
         if (a_valid && a_alu == 5'h10) mulc++;
         if (a_stall) stc++;
         if (a_md_last) begin mdc++; lastk = k; end
         if (addk == 0 && a_valid && a_alu == 5'h00) addk = k;
      end
      check("mul_hold", mulc, 3);
      check("mul_stall", stc, 2);
      check("mul_last_cyc", lastk, 3);
      check("mul_last_cnt", mdc, 1);
      check("add_after_mul", addk, 4);
      cycle(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);

      // div flushed on its 10th BUSY cycle
      mdc = 0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 1) cycle(1'b1, R, 3'd4, 7'h01, 1'b0, 1'b0);
         else        cycle(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
         if (a_md_last) mdc++;
      end
      check("div_busy10", {31'd0, a_stall}, 32'd1);
      cycle(1'b1, R, 3'd0, 7'h00, 1'b0, 1'b1);
      check("flush_bubble", {30'd0, a_valid, a_stall}, 32'd0);
      if (a_md_last) mdc++;
      check("flush_no_last", mdc, 0);

      // div with 5 stall_i cycles: 38 cycles of occupancy
      mdc = 0;
      cycle(1'b1, R, 3'd4, 7'h01, 1'b0, 1'b0);
      occ_cnt = (a_valid && a_alu == 5'h14) ? 1 : 0;
      for (int g = 2; g < 80; g++) begin
         cycle(1'b0, 7'd0, 3'd0, 7'd0, (g >= 5 && g <= 9), 1'b0);
         if (a_md_last) mdc++;
         if (a_valid && a_alu == 5'h14) occ_cnt++;
         else break;
      end
      check("div_occupancy", occ_cnt, 38);
      check("div_last_cnt", mdc, 1);

      // asynchronous reset in the middle of a BUSY div
      cycle(1'b1, R, 3'd5, 7'h01, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", {13'd0, act_a, a_stall}, 32'd0);
      mex = '0; occ = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         ro = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 9) == 0) ro = 7'($urandom_range(0, 127));
         case ($urandom_range(0, 3))
            0: rf7 = 7'h00;
            1: rf7 = 7'h20;
            2: rf7 = 7'h01;
            default: rf7 = 7'($urandom_range(0, 127));
         endcase
         cycle($urandom_range(0, 9) < 7, ro, 3'($urandom_range(0, 7)), rf7,
               $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
